// File: rtl/ccsds_checker_pkg.sv
// Shared types for the CCSDS AXIS output checker: FSM states and failure codes.
package ccsds_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } checker_state_t;

    typedef enum logic [2:0] {
        FAIL_NONE         = 3'd0,
        FAIL_DATA         = 3'd1,
        FAIL_EARLY_LAST   = 3'd2,
        FAIL_MISSING_LAST = 3'd3,
        FAIL_TIMEOUT      = 3'd4
    } fail_code_t;

endpackage

// File: rtl/ccsds_checker_watchdog.sv
// No-progress watchdog: counts enabled cycles since the last clear.
// expire is registered and is high exactly while count == TIMEOUT_CYCLES-1.
module ccsds_checker_watchdog #(
    parameter int unsigned CNT_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 217500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] count_inc;

    assign count_inc = count + CNT_WIDTH'(1);

    // Counter and look-ahead expire flag; the counter saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            expire <= 1'b0;
        end else if (clear) begin
            count  <= '0;
            expire <= (LIMIT == '0);
        end else if (enable && (count != '1)) begin
            count  <= count_inc;
            expire <= (count_inc == LIMIT);
        end
    end

endmodule

// File: rtl/ccsds_axis_output_checker.sv
// Self-test checker for the CCSDS 123.0-B.2 compressed AXIS output.
// Compares the DUT stream word-for-word against a golden stream, checks the
// stream length and last placement, watches for stalls and keeps a checksum.
// Optional build macro: CHECKER_MISMATCH_LOG_EN (captures the first mismatching word pair).
module ccsds_axis_output_checker
    import ccsds_checker_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned CNT_WIDTH      = 32,
    parameter int unsigned EXPECTED_WORDS = 841,
    parameter int unsigned TIMEOUT_CYCLES = 217500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dut_data,
    input  logic                  dut_valid,
    input  logic                  dut_last,
    output logic                  dut_ready,
    input  logic [DATA_WIDTH-1:0] ref_data,
    input  logic                  ref_valid,
    output logic                  ref_ready,
    output logic                  busy,
    output logic                  finished,
    output logic                  failed,
    output logic [2:0]            fail_code,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [CNT_WIDTH-1:0]  first_mismatch_idx,
    output logic [DATA_WIDTH-1:0] checksum,
    output logic [DATA_WIDTH-1:0] mismatch_exp,
    output logic [DATA_WIDTH-1:0] mismatch_got
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(EXPECTED_WORDS - 1);

    checker_state_t state;
    checker_state_t state_next;
    fail_code_t     code_q;

    logic xfer;
    logic arm;
    logic mismatch;
    logic early_last;
    logic missing_last;
    logic timeout;
    logic code_free;
    logic wd_expire;

    assign xfer         = (state == RUN) && dut_valid && ref_valid;
    assign mismatch     = xfer && (dut_data != ref_data);
    assign early_last   = xfer && dut_last && (word_count < LAST_IDX);
    assign missing_last = xfer && !dut_last && (word_count == LAST_IDX);
    assign timeout      = (state == RUN) && !xfer && wd_expire;
    assign code_free    = (code_q == FAIL_NONE);
    assign fail_code    = code_q;

    ccsds_checker_watchdog #(
        .CNT_WIDTH      (CNT_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  ((state != RUN) || xfer),
        .enable ((state == RUN) && !xfer),
        .expire (wd_expire)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, handshake readies and busy; readies only look at the other side's valid.
    always_comb begin
        state_next = state;
        arm        = 1'b0;
        dut_ready  = 1'b0;
        ref_ready  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    arm        = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy      = 1'b1;
                dut_ready = ref_valid;
                ref_ready = dut_valid;
                if (xfer) begin
                    if (dut_last || (word_count == LAST_IDX)) begin
                        state_next = DONE;
                    end
                end else if (wd_expire) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters, checksum and sticky verdict; only the first failure cause is recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count         <= '0;
            checksum           <= '0;
            failed             <= 1'b0;
            finished           <= 1'b0;
            code_q             <= FAIL_NONE;
            first_mismatch_idx <= '1;
        end else if (arm) begin
            word_count         <= '0;
            checksum           <= '0;
            failed             <= 1'b0;
            finished           <= 1'b0;
            code_q             <= FAIL_NONE;
            first_mismatch_idx <= '1;
        end else begin
            if (xfer) begin
                if (word_count != '1) begin
                    word_count <= word_count + CNT_WIDTH'(1);
                end
                checksum <= {checksum[DATA_WIDTH-2:0], checksum[DATA_WIDTH-1]} ^ dut_data;
            end
            if (mismatch || early_last || missing_last || timeout) begin
                failed <= 1'b1;
            end
            if (code_free) begin
                if (mismatch) begin
                    code_q             <= FAIL_DATA;
                    first_mismatch_idx <= word_count;
                end else if (early_last) begin
                    code_q <= FAIL_EARLY_LAST;
                end else if (missing_last) begin
                    code_q <= FAIL_MISSING_LAST;
                end else if (timeout) begin
                    code_q <= FAIL_TIMEOUT;
                end
            end
            if ((state == RUN) && (state_next == DONE)) begin
                finished <= 1'b1;
            end
        end
    end

`ifdef CHECKER_MISMATCH_LOG_EN
    logic [DATA_WIDTH-1:0] exp_q;
    logic [DATA_WIDTH-1:0] got_q;

    // Capture the word pair of the first data mismatch; held until start or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q <= '0;
            got_q <= '0;
        end else if (arm) begin
            exp_q <= '0;
            got_q <= '0;
        end else if (mismatch && code_free) begin
            exp_q <= ref_data;
            got_q <= dut_data;
        end
    end

    assign mismatch_exp = exp_q;
    assign mismatch_got = got_q;
`else
    assign mismatch_exp = '0;
    assign mismatch_got = '0;
`endif

endmodule

// File: tb/tb_ccsds_axis_output_checker.sv
// Self-checking bench for ccsds_axis_output_checker: table of stream scenarios
// plus hand-written timeout, stall and mid-run reset sequences.
module tb_ccsds_axis_output_checker;

    localparam int NW = 841;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] dut_data = '0;
    logic        dut_valid = 1'b0;
    logic        dut_last = 1'b0;
    logic        dut_ready;
    logic [63:0] ref_data = '0;
    logic        ref_valid = 1'b0;
    logic        ref_ready;
    logic        busy;
    logic        finished;
    logic        failed;
    logic [2:0]  fail_code;
    logic [31:0] word_count;
    logic [31:0] first_mismatch_idx;
    logic [63:0] checksum;
    logic [63:0] mismatch_exp;
    logic [63:0] mismatch_got;

    ccsds_axis_output_checker #(
        .DATA_WIDTH     (64),
        .CNT_WIDTH      (32),
        .EXPECTED_WORDS (NW),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .dut_data           (dut_data),
        .dut_valid          (dut_valid),
        .dut_last           (dut_last),
        .dut_ready          (dut_ready),
        .ref_data           (ref_data),
        .ref_valid          (ref_valid),
        .ref_ready          (ref_ready),
        .busy               (busy),
        .finished           (finished),
        .failed             (failed),
        .fail_code          (fail_code),
        .word_count         (word_count),
        .first_mismatch_idx (first_mismatch_idx),
        .checksum           (checksum),
        .mismatch_exp       (mismatch_exp),
        .mismatch_got       (mismatch_got)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          last_pos;
        int          flip_a;
        int          flip_b;
        int          ndut;
        int          exp_code;
        int          exp_count;
        logic [31:0] exp_idx;
    } case_t;

    case_t       cases[6];
    logic [63:0] ref_words[NW];
    logic [63:0] dut_words[NW];
    bit          dut_lasts[NW];
    int          gap_pct;
    int          stall_idx;
    int          stall_left;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic prepare(input int last_pos, input int flip_a, input int flip_b);
        for (int i = 0; i < NW; i++) begin
            ref_words[i] = {$urandom, $urandom};
            dut_words[i] = ref_words[i];
            dut_lasts[i] = (i == last_pos);
        end
        if (flip_a >= 0) dut_words[flip_a] = dut_words[flip_a] ^ 64'd1;
        if (flip_b >= 0) dut_words[flip_b] = dut_words[flip_b] ^ 64'd1;
        stall_idx  = -1;
        stall_left = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents words with random valid gaps on both sides until ndut DUT words are accepted.
    task automatic drive(input int ndut, input int budget);
        int di = 0;
        for (int cyc = 0; cyc < budget && di < ndut && !finished; cyc++) begin
            @(negedge clk);
            if (di == stall_idx && stall_left > 0) begin
                dut_valid = 1'b0;
                stall_left--;
            end else begin
                dut_valid = ($urandom_range(0, 99) >= gap_pct);
            end
            ref_valid = ($urandom_range(0, 99) >= gap_pct);
            dut_data  = dut_words[di];
            dut_last  = dut_lasts[di];
            ref_data  = ref_words[di];
            #1;
            if (dut_valid && dut_ready) di++;
        end
        @(negedge clk);
        dut_valid = 1'b0;
        ref_valid = 1'b0;
        dut_last  = 1'b0;
        if (di < ndut && !finished) chk("drive_budget", 64'(di), 64'(ndut));
    endtask

    task automatic wait_finished(input string nm);
        for (int k = 0; k < 50 && !finished; k++) @(negedge clk);
        chk($sformatf("%s:finished", nm), 64'(finished), 64'd1);
    endtask

    // Reference: checksum is a rotate-left-by-one then XOR over the accepted words.
    function automatic logic [63:0] model_checksum(input int n);
        logic [63:0] c = '0;
        for (int i = 0; i < n; i++) c = ((c << 1) | (c >> 63)) ^ dut_words[i];
        return c;
    endfunction

    function automatic int model_first_diff(input int n);
        for (int i = 0; i < n; i++) if (dut_words[i] != ref_words[i]) return i;
        return -1;
    endfunction

    task automatic check_ready_closed(input string nm);
        dut_valid = 1'b1;
        ref_valid = 1'b1;
        #1;
        chk($sformatf("%s:dut_ready_closed", nm), 64'(dut_ready), 64'd0);
        chk($sformatf("%s:ref_ready_closed", nm), 64'(ref_ready), 64'd0);
        chk($sformatf("%s:busy_low", nm), 64'(busy), 64'd0);
        dut_valid = 1'b0;
        ref_valid = 1'b0;
    endtask

    task automatic run_case(input case_t tc);
        int          fd;
        logic [63:0] e_exp;
        logic [63:0] e_got;
        prepare(tc.last_pos, tc.flip_a, tc.flip_b);
        pulse_start();
        chk($sformatf("%s:busy", tc.name), 64'(busy), 64'd1);
        chk($sformatf("%s:cleared_count", tc.name), 64'(word_count), 64'd0);
        drive(tc.ndut, 20000);
        wait_finished(tc.name);
        chk($sformatf("%s:failed", tc.name), 64'(failed), 64'(tc.exp_code != 0));
        chk($sformatf("%s:fail_code", tc.name), 64'(fail_code), 64'(tc.exp_code));
        chk($sformatf("%s:word_count", tc.name), 64'(word_count), 64'(tc.exp_count));
        chk($sformatf("%s:first_idx", tc.name), 64'(first_mismatch_idx), 64'(tc.exp_idx));
        chk($sformatf("%s:checksum", tc.name), checksum, model_checksum(tc.exp_count));
        fd    = model_first_diff(tc.exp_count);
        e_exp = '0;
        e_got = '0;
`ifdef CHECKER_MISMATCH_LOG_EN
        if (fd >= 0) begin
            e_exp = ref_words[fd];
            e_got = dut_words[fd];
        end
`endif
        chk($sformatf("%s:mismatch_exp", tc.name), mismatch_exp, e_exp);
        chk($sformatf("%s:mismatch_got", tc.name), mismatch_got, e_got);
        check_ready_closed(tc.name);
    endtask

    initial begin
        cases[0] = '{"nominal",      840, -1,  -1,  NW,  0, 841, 32'hFFFF_FFFF};
        cases[1] = '{"mismatch",     840, 17,  300, NW,  1, 841, 32'd17};
        cases[2] = '{"early_last",   500, -1,  -1,  501, 2, 501, 32'hFFFF_FFFF};
        cases[3] = '{"missing_last", -1,  -1,  -1,  NW,  3, 841, 32'hFFFF_FFFF};
        cases[4] = '{"mis_and_last", 500, 500, -1,  501, 1, 501, 32'd500};
        cases[5] = '{"last_first",   0,   -1,  -1,  1,   2, 1,   32'hFFFF_FFFF};
        gap_pct  = 25;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst:busy", 64'(busy), 64'd0);
        chk("rst:finished", 64'(finished), 64'd0);
        chk("rst:failed", 64'(failed), 64'd0);
        chk("rst:fail_code", 64'(fail_code), 64'd0);
        chk("rst:word_count", 64'(word_count), 64'd0);
        chk("rst:first_idx", 64'(first_mismatch_idx), 64'hFFFF_FFFF);
        chk("rst:checksum", checksum, 64'd0);
        check_ready_closed("rst");
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 6; t++) run_case(cases[t]);

        // Timeout: 10 words, then the DUT goes silent
        gap_pct = 0;
        prepare(840, -1, -1);
        pulse_start();
        drive(10, 2000);
        repeat (99) @(negedge clk);
        chk("timeout:not_yet", 64'(finished), 64'd0);
        @(negedge clk);
        chk("timeout:finished", 64'(finished), 64'd1);
        chk("timeout:failed", 64'(failed), 64'd1);
        chk("timeout:fail_code", 64'(fail_code), 64'd4);
        chk("timeout:word_count", 64'(word_count), 64'd10);

        // A 99-cycle stall followed by a transfer must not time out
        prepare(840, -1, -1);
        stall_idx  = 5;
        stall_left = 99;
        pulse_start();
        drive(NW, 5000);
        wait_finished("stall99");
        chk("stall99:fail_code", 64'(fail_code), 64'd0);
        chk("stall99:word_count", 64'(word_count), 64'd841);
        chk("stall99:checksum", checksum, model_checksum(NW));

        // Mid-run reset at word 200, then a clean pass
        gap_pct = 25;
        prepare(840, 3, -1);
        pulse_start();
        drive(200, 5000);
        chk("midrst:count_before", 64'(word_count), 64'd200);
        ref_valid = 1'b1;
        rst_n     = 1'b0;
        #1;
        chk("midrst:word_count", 64'(word_count), 64'd0);
        chk("midrst:failed", 64'(failed), 64'd0);
        chk("midrst:fail_code", 64'(fail_code), 64'd0);
        chk("midrst:first_idx", 64'(first_mismatch_idx), 64'hFFFF_FFFF);
        chk("midrst:checksum", checksum, 64'd0);
        chk("midrst:busy", 64'(busy), 64'd0);
        chk("midrst:dut_ready", 64'(dut_ready), 64'd0);
        chk("midrst:mismatch_got", mismatch_got, 64'd0);
        ref_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_case(cases[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
